multi_alarm_timekeeper: RTL and testbench

- Parametrised successor to the single-alarm hour/min/sec core: 24-hour timekeeper with on-chip second-tick divider, ALARM_NUM independent alarm channels, per-channel ring/snooze FSM and 12/24-hour display hour conversion.
- Sits between the switch controller (register writes, snooze/stop pulses) and the digit separator/FND/buzzer path.
- The OR of ringing channels drives the buzzer enable.

---
 rtl/multi_alarm_timekeeper.sv | 252 +++++++++++++++++++++++++
 tb/tb_multi_alarm_timekeeper.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_timekeeper.sv
// 24-hour timekeeper with a second-tick divider, ALARM_NUM ring/snooze alarm channels
// and a 12/24-hour display hour. The OR of ringing channels drives the buzzer enable.
module multi_alarm_timekeeper #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned ALARM_NUM  = 4,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    localparam int unsigned SELW      = $clog2(ALARM_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_time_wr,
    input  logic [4:0]           i_hour,
    input  logic [5:0]           i_min,
    input  logic [5:0]           i_sec,
    input  logic                 i_alm_wr,
    input  logic [SELW-1:0]      i_alm_sel,
    input  logic [4:0]           i_alm_hour,
    input  logic [5:0]           i_alm_min,
    input  logic                 i_alm_en,
    input  logic                 i_snooze,
    input  logic                 i_stop,
    input  logic                 i_mode_12h,
    output logic [4:0]           o_hour,
    output logic [5:0]           o_min,
    output logic [5:0]           o_sec,
    output logic [4:0]           o_disp_hour,
    output logic                 o_pm,
    output logic                 o_tick,
    output logic                 o_day_wrap,
    output logic [ALARM_NUM-1:0] o_alarm_vec,
    output logic                 o_alarm,
    output logic                 o_wr_err
);

    localparam int unsigned DIVW    = $clog2(CLK_FREQ);
    localparam int unsigned SNZ_SEC = SNOOZE_MIN * 60;
    localparam int unsigned CNT_MAX = (RING_SEC > SNZ_SEC) ? RING_SEC : SNZ_SEC;
    localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } ch_state_e;

    logic [DIVW-1:0]      r_div;
    logic [4:0]           r_hour;
    logic [5:0]           r_min;
    logic [5:0]           r_sec;
    logic                 r_tick;
    logic                 r_day_wrap;
    logic                 r_wr_err;
    logic [4:0]           r_alm_hour [ALARM_NUM];
    logic [5:0]           r_alm_min  [ALARM_NUM];
    logic [ALARM_NUM-1:0] r_alm_en;
    ch_state_e            r_state    [ALARM_NUM];
    logic [CNTW-1:0]      r_cnt      [ALARM_NUM];
    logic [ALARM_NUM-1:0] r_alarm_vec;
    logic                 r_alarm;

    logic                 w_time_ok;
    logic                 w_time_load;
    logic                 w_alm_ok;
    logic                 w_alm_load;
    logic [ALARM_NUM-1:0] w_sel_hit;
    logic                 w_term;
    logic                 w_adv;
    logic [4:0]           w_hour_nxt;
    logic [5:0]           w_min_nxt;
    logic [5:0]           w_sec_nxt;
    logic                 w_wrap;
    logic [ALARM_NUM-1:0] w_match;
    logic [ALARM_NUM-1:0] w_dis;
    ch_state_e            w_state_nxt [ALARM_NUM];
    logic [CNTW-1:0]      w_cnt_nxt   [ALARM_NUM];
    logic [ALARM_NUM-1:0] w_vec_nxt;
    logic [4:0]           w_disp_hour;

    // Decoded select avoids a width-dependent range compare on i_alm_sel
    always_comb begin
        for (int i = 0; i < ALARM_NUM; i++) begin
            w_sel_hit[i] = (i_alm_sel == SELW'(i));
        end
    end

    assign w_time_ok   = (i_hour < 5'd24) && (i_min < 6'd60) && (i_sec < 6'd60);
    assign w_time_load = i_time_wr && w_time_ok;
    assign w_alm_ok    = (i_alm_hour < 5'd24) && (i_alm_min < 6'd60) && (|w_sel_hit);
    assign w_alm_load  = i_alm_wr && w_alm_ok;
    assign w_term      = (r_div == DIVW'(CLK_FREQ - 1));
    assign w_adv       = w_term && !w_time_load;

    // Time one second later, with carry chain and day wrap flag
    always_comb begin
        w_sec_nxt  = r_sec + 6'd1;
        w_min_nxt  = r_min;
        w_hour_nxt = r_hour;
        w_wrap     = 1'b0;
        if (r_sec == 6'd59) begin
            w_sec_nxt = 6'd0;
            w_min_nxt = r_min + 6'd1;
            if (r_min == 6'd59) begin
                w_min_nxt  = 6'd0;
                w_hour_nxt = r_hour + 5'd1;
                if (r_hour == 5'd23) begin
                    w_hour_nxt = 5'd0;
                    w_wrap     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_hour     <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_tick     <= 1'b0;
            r_day_wrap <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_tick     <= w_adv;
            r_day_wrap <= w_adv && w_wrap;
            r_wr_err   <= (i_time_wr && !w_time_ok) || (i_alm_wr && !w_alm_ok);
            if (w_time_load) begin
                r_div  <= '0;
                r_hour <= i_hour;
                r_min  <= i_min;
                r_sec  <= i_sec;
            end else if (w_term) begin
                r_div  <= '0;
                r_hour <= w_hour_nxt;
                r_min  <= w_min_nxt;
                r_sec  <= w_sec_nxt;
            end else begin
                r_div <= r_div + DIVW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alm_en <= '0;
            for (int i = 0; i < ALARM_NUM; i++) begin
                r_alm_hour[i] <= '0;
                r_alm_min[i]  <= '0;
            end
        end else if (w_alm_load) begin
            for (int i = 0; i < ALARM_NUM; i++) begin
                if (w_sel_hit[i]) begin
                    r_alm_hour[i] <= i_alm_hour;
                    r_alm_min[i]  <= i_alm_min;
                    r_alm_en[i]   <= i_alm_en;
                end
            end
        end
    end

    // Match only on a tick advance, against the time being loaded; uses pre-write alarm settings
    always_comb begin
        for (int i = 0; i < ALARM_NUM; i++) begin
            w_match[i] = w_adv && (w_sec_nxt == 6'd0) && (w_hour_nxt == r_alm_hour[i])
                         && (w_min_nxt == r_alm_min[i]) && r_alm_en[i];
            w_dis[i]   = w_alm_load && w_sel_hit[i] && !i_alm_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alarm_vec <= '0;
            r_alarm     <= 1'b0;
            for (int i = 0; i < ALARM_NUM; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_alarm_vec <= w_vec_nxt;
            r_alarm     <= |w_vec_nxt;
            for (int i = 0; i < ALARM_NUM; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Priority: disable write > stop > snooze > match > expiry
    always_comb begin
        for (int i = 0; i < ALARM_NUM; i++) begin
            w_state_nxt[i] = r_state[i];
            if (w_dis[i]) begin
                w_state_nxt[i] = ST_IDLE;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_match[i]) w_state_nxt[i] = ST_RING;
                    end
                    ST_RING: begin
                        if (i_stop)                                w_state_nxt[i] = ST_IDLE;
                        else if (i_snooze)                         w_state_nxt[i] = ST_SNOOZE;
                        else if (w_match[i])                       w_state_nxt[i] = ST_RING;
                        else if (w_adv && r_cnt[i] <= CNTW'(1))    w_state_nxt[i] = ST_IDLE;
                    end
                    ST_SNOOZE: begin
                        if (i_stop)                                w_state_nxt[i] = ST_IDLE;
                        else if (w_match[i])                       w_state_nxt[i] = ST_RING;
                        else if (w_adv && r_cnt[i] <= CNTW'(1))    w_state_nxt[i] = ST_RING;
                    end
                    default: w_state_nxt[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Counter reload on state entry or re-match, else count down per tick
    always_comb begin
        for (int i = 0; i < ALARM_NUM; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_vec_nxt[i] = (w_state_nxt[i] == ST_RING);
            if (w_state_nxt[i] == ST_IDLE) begin
                w_cnt_nxt[i] = '0;
            end else if (w_state_nxt[i] == ST_RING && (w_match[i] || r_state[i] != ST_RING)) begin
                w_cnt_nxt[i] = CNTW'(RING_SEC);
            end else if (w_state_nxt[i] == ST_SNOOZE && r_state[i] != ST_SNOOZE) begin
                w_cnt_nxt[i] = CNTW'(SNZ_SEC);
            end else if (w_adv) begin
                w_cnt_nxt[i] = r_cnt[i] - CNTW'(1);
            end
        end
    end

    always_comb begin
        w_disp_hour = r_hour;
        if (i_mode_12h) begin
            if (r_hour == 5'd0)       w_disp_hour = 5'd12;
            else if (r_hour > 5'd12)  w_disp_hour = r_hour - 5'd12;
        end
    end

    assign o_hour      = r_hour;
    assign o_min       = r_min;
    assign o_sec       = r_sec;
    assign o_disp_hour = w_disp_hour;
    assign o_pm        = i_mode_12h && (r_hour >= 5'd12);
    assign o_tick      = r_tick;
    assign o_day_wrap  = r_day_wrap;
    assign o_alarm_vec = r_alarm_vec;
    assign o_alarm     = r_alarm;
    assign o_wr_err    = r_wr_err;

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Scoreboard bench: a seconds-of-day reference model predicts every output event
// (tick, write error, alarm vector change); a monitor pops and compares each DUT event.
module tb_multi_alarm_timekeeper;

    localparam int F  = 4;
    localparam int N  = 3;
    localparam int RS = 3;
    localparam int SM = 1;

    typedef struct packed {
        logic         tick;
        logic         wrap;
        logic         err;
        logic [N-1:0] vec;
        logic         alarm;
        logic [4:0]   h;
        logic [5:0]   m;
        logic [5:0]   s;
        logic [4:0]   dh;
        logic         pm;
    } obs_t;

    logic         clk, rst_n;
    logic         time_wr, alm_wr, alm_en, snooze, stop, mode;
    logic [4:0]   hour, alm_hour;
    logic [5:0]   min, sec, alm_min;
    logic [1:0]   alm_sel;
    logic [4:0]   o_hour, o_disp_hour;
    logic [5:0]   o_min, o_sec;
    logic         o_pm, o_tick, o_day_wrap, o_alarm, o_wr_err;
    logic [N-1:0] o_alarm_vec;

    multi_alarm_timekeeper #(
        .CLK_FREQ(F), .ALARM_NUM(N), .RING_SEC(RS), .SNOOZE_MIN(SM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_time_wr(time_wr), .i_hour(hour), .i_min(min), .i_sec(sec),
        .i_alm_wr(alm_wr), .i_alm_sel(alm_sel), .i_alm_hour(alm_hour),
        .i_alm_min(alm_min), .i_alm_en(alm_en),
        .i_snooze(snooze), .i_stop(stop), .i_mode_12h(mode),
        .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
        .o_disp_hour(o_disp_hour), .o_pm(o_pm), .o_tick(o_tick),
        .o_day_wrap(o_day_wrap), .o_alarm_vec(o_alarm_vec), .o_alarm(o_alarm),
        .o_wr_err(o_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    obs_t exp_q[$];
    bit mon_en = 1'b0;

    // Reference model state: time as seconds of day, channels as remaining seconds
    int m_tod, m_div;
    int m_ah [N];
    int m_am [N];
    bit m_en [N];
    int m_ring [N];
    int m_snz [N];
    logic [N-1:0] m_prev_vec;
    int rnd, tgt, guard;
    int exp_dh [4];
    int exp_pm [4];
    int hours  [4];

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d need %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        bit tw_ok, aw_ok, err, term, adv, match;
        int old_tod;
        obs_t e;
        tw_ok   = time_wr && hour < 24 && min < 60 && sec < 60;
        aw_ok   = alm_wr && alm_sel < N && alm_hour < 24 && alm_min < 60;
        err     = (time_wr && !tw_ok) || (alm_wr && !aw_ok);
        old_tod = m_tod;
        term    = (m_div == F - 1);
        adv     = term && !tw_ok;
        if (tw_ok) begin
            m_tod = hour * 3600 + min * 60 + sec;
            m_div = 0;
        end else if (term) begin
            m_tod = (m_tod + 1) % 86400;
            m_div = 0;
        end else begin
            m_div++;
        end
        for (int i = 0; i < N; i++) begin
            match = adv && (m_tod % 60 == 0) && (m_tod / 60 == m_ah[i] * 60 + m_am[i]) && m_en[i];
            if (aw_ok && alm_sel == i && !alm_en) begin
                m_ring[i] = 0; m_snz[i] = 0;
            end else if (stop && (m_ring[i] > 0 || m_snz[i] > 0)) begin
                m_ring[i] = 0; m_snz[i] = 0;
            end else if (snooze && m_ring[i] > 0) begin
                m_ring[i] = 0; m_snz[i] = SM * 60;
            end else if (match) begin
                m_ring[i] = RS; m_snz[i] = 0;
            end else if (adv) begin
                if (m_ring[i] > 0) m_ring[i]--;
                else if (m_snz[i] > 0) begin
                    m_snz[i]--;
                    if (m_snz[i] == 0) m_ring[i] = RS;
                end
            end
        end
        if (aw_ok) begin
            m_ah[alm_sel] = alm_hour;
            m_am[alm_sel] = alm_min;
            m_en[alm_sel] = alm_en;
        end
        e.tick = adv;
        e.wrap = adv && old_tod == 86399;
        e.err  = err;
        for (int i = 0; i < N; i++) e.vec[i] = (m_ring[i] > 0);
        e.alarm = |e.vec;
        e.h  = 5'(m_tod / 3600);
        e.m  = 6'((m_tod / 60) % 60);
        e.s  = 6'(m_tod % 60);
        e.dh = mode ? 5'(((m_tod / 3600) + 11) % 12 + 1) : e.h;
        e.pm = mode && (m_tod >= 12 * 3600);
        if (e.tick || e.err || e.vec != m_prev_vec) exp_q.push_back(e);
        m_prev_vec = e.vec;
    endtask

    // One clock: model consumes the inputs set at this negedge, then pulses drop
    task automatic cycle();
        model_step();
        @(negedge clk);
        time_wr = 1'b0; alm_wr = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wr_time(input int h, input int m, input int s);
        time_wr = 1'b1; hour = 5'(h); min = 6'(m); sec = 6'(s);
        cycle();
    endtask

    task automatic wr_alm(input int ch, input int h, input int m, input bit en);
        alm_wr = 1'b1; alm_sel = 2'(ch); alm_hour = 5'(h); alm_min = 6'(m); alm_en = en;
        cycle();
    endtask

    task automatic wait_ring(input int ch);
        guard = 0;
        while (m_ring[ch] == 0 && guard < 400) begin
            cycle();
            guard++;
        end
        check("ring_wait_bound", guard < 400, 1);
    endtask

    // Monitor: every DUT event pops one prediction
    initial begin : monitor
        obs_t a, e;
        logic [N-1:0] prev_vec;
        prev_vec = '0;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            a = '{o_tick, o_day_wrap, o_wr_err, o_alarm_vec, o_alarm,
                  o_hour, o_min, o_sec, o_disp_hour, o_pm};
            if (o_tick || o_wr_err || o_alarm_vec != prev_vec) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got %h need none at %0t", a, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (a != e) begin
                        n_bad++;
                        $display("FAIL event: got tick=%0d wrap=%0d err=%0d vec=%b al=%0d t=%0d:%0d:%0d dh=%0d pm=%0d need tick=%0d wrap=%0d err=%0d vec=%b al=%0d t=%0d:%0d:%0d dh=%0d pm=%0d at %0t",
                                 a.tick, a.wrap, a.err, a.vec, a.alarm, a.h, a.m, a.s, a.dh, a.pm,
                                 e.tick, e.wrap, e.err, e.vec, e.alarm, e.h, e.m, e.s, e.dh, e.pm, $time);
                    end
                end
            end
            prev_vec = o_alarm_vec;
        end
    end

    initial begin
        rst_n = 1'b0;
        time_wr = 1'b0; alm_wr = 1'b0; snooze = 1'b0; stop = 1'b0; mode = 1'b0;
        hour = '0; min = '0; sec = '0; alm_sel = '0; alm_hour = '0; alm_min = '0; alm_en = 1'b0;
        m_tod = 0; m_div = 0; m_prev_vec = '0;
        for (int i = 0; i < N; i++) begin
            m_ah[i] = 0; m_am[i] = 0; m_en[i] = 1'b0; m_ring[i] = 0; m_snz[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_hour", o_hour, 0);
        check("rst_min", o_min, 0);
        check("rst_sec", o_sec, 0);
        check("rst_vec", o_alarm_vec, 0);
        check("rst_pulses", {o_tick, o_day_wrap, o_wr_err, o_alarm}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Day wrap
        wr_time(23, 59, 58);
        run(8);

        // Rejected writes
        wr_time(10, 60, 0);
        check("time_err", o_wr_err, 1);
        check("time_kept", o_min, 0);
        run(2);
        wr_alm(N, 1, 1, 1'b1);
        check("sel_err", o_wr_err, 1);
        wr_alm(0, 24, 0, 1'b1);
        run(2);

        // Ring then timeout
        wr_alm(0, 0, 1, 1'b1);
        wr_time(0, 0, 59);
        wait_ring(0);
        check("ring_vec", o_alarm_vec, 1);
        run(4 * F);
        check("ring_timeout", o_alarm_vec, 0);

        // Snooze, re-ring, snooze+stop together
        wr_time(0, 0, 59);
        wait_ring(0);
        snooze = 1'b1;
        cycle();
        check("snoozed", o_alarm, 0);
        wait_ring(0);
        check("re_ring", o_alarm, 1);
        snooze = 1'b1; stop = 1'b1;
        cycle();
        check("snooze_stop", o_alarm, 0);
        run(8 * F);

        // Two channels at once, disable one, then stop
        wr_alm(1, 0, 2, 1'b1);
        wr_alm(2, 0, 2, 1'b1);
        wr_time(0, 1, 59);
        wait_ring(1);
        check("two_ch", o_alarm_vec, 6);
        wr_alm(1, 0, 2, 1'b0);
        check("ch1_dis", o_alarm_vec, 4);
        stop = 1'b1;
        cycle();
        check("stop_all", o_alarm_vec, 0);
        run(2 * F);

        // 12-hour display
        hours  = '{0, 12, 13, 23};
        exp_dh = '{12, 12, 1, 11};
        exp_pm = '{0, 1, 1, 1};
        mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_time(hours[k], 30, 10);
            check("disp_hour", o_disp_hour, exp_dh[k]);
            check("pm", o_pm, exp_pm[k]);
            run(F);
        end
        mode = 1'b0;

        // Time write landing on hh:mm:00 does not ring
        wr_alm(0, 5, 30, 1'b1);
        wr_time(5, 30, 0);
        run(3 * F);
        check("write_no_ring", o_alarm, 0);

        // Randomized traffic
        for (int k = 0; k < 5000; k++) begin
            rnd = $urandom_range(0, 999);
            if (rnd < 4) begin
                time_wr = 1'b1;
                hour = 5'($urandom_range(0, (rnd == 0) ? 31 : 23));
                min  = 6'($urandom_range(0, (rnd == 1) ? 63 : 59));
                sec  = 6'($urandom_range(45, 59));
            end else if (rnd < 16) begin
                tgt = (m_tod / 60 + $urandom_range(0, 1)) % 1440;
                alm_wr   = 1'b1;
                alm_sel  = 2'($urandom_range(0, 3));
                alm_hour = 5'((rnd == 5) ? 25 : tgt / 60);
                alm_min  = 6'(tgt % 60);
                alm_en   = ($urandom_range(0, 4) != 0);
            end else if (rnd < 26) begin
                snooze = 1'b1;
                stop   = (rnd == 16);
            end else if (rnd < 31) begin
                stop = 1'b1;
            end else if (rnd < 34) begin
                mode = ~mode;
            end
            cycle();
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
